// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the FU writeback arbiter: beat record, width constants, rr helpers.
// Build option WB_BYPASS_EN (see fu_wb_arbiter.sv) does not change anything here.
package fu_wb_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int FU_COUNT     = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int DATA_BITS    = 64;

  localparam int FU_IDX_BITS  = $clog2(FU_COUNT);
  localparam int PTR_BITS     = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS     = PTR_BITS + 1;

  typedef logic [INST_ID_BITS-1:0] inst_id_t;
  typedef logic [PRN_BITS-1:0]     prn_t;
  typedef logic [DATA_BITS-1:0]    data_t;
  typedef logic [FU_IDX_BITS-1:0]  fu_idx_t;
  typedef logic [PTR_BITS-1:0]     ptr_t;
  typedef logic [CNT_BITS-1:0]     cnt_t;
  typedef logic [CNT_BITS:0]       occ_t;

  // Occupancy (buffered + beat arriving now) that still leaves room for one more in-flight beat.
  localparam occ_t OCC_LIMIT = occ_t'(FIFO_DEPTH - 2);

  typedef struct packed {
    inst_id_t                       inst_id;
    prn_t  [MAX_OPERANDS-1:0]       prn;
    data_t [MAX_OPERANDS-1:0]       data;
    logic  [MAX_OPERANDS-1:0]       data_valid;
  } wb_beat_t;

  typedef struct packed {
    logic    found;
    fu_idx_t idx;
  } rr_pick_t;

  function automatic wb_beat_t mask_beat(input wb_beat_t b);
    wb_beat_t m;
    m = b;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (!b.data_valid[k]) begin
        m.prn[k]  = '0;
        m.data[k] = '0;
      end
    end
    return m;
  endfunction

  // First requester at or after ptr, wrapping modulo FU_COUNT.
  function automatic rr_pick_t rr_pick(input logic [FU_COUNT-1:0] req, input fu_idx_t ptr);
    rr_pick_t r;
    int       idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int off = FU_COUNT - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= FU_COUNT) idx = idx - FU_COUNT;
      if (req[fu_idx_t'(idx)]) begin
        r.found = 1'b1;
        r.idx   = fu_idx_t'(idx);
      end
    end
    return r;
  endfunction

  function automatic fu_idx_t rr_next(input fu_idx_t g);
    if (int'(g) == FU_COUNT - 1) return '0;
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU result / PRF write / ROB completion bundle between the FU wrappers and the writeback arbiter.
interface fu_wb_arbiter_if;
  import fu_wb_pkg::*;

  logic [FU_COUNT-1:0]     fu_valid;
  inst_id_t                fu_inst_id    [FU_COUNT];
  prn_t                    fu_prn        [FU_COUNT][MAX_OPERANDS];
  data_t                   fu_data       [FU_COUNT][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] fu_data_valid [FU_COUNT];
  logic [FU_COUNT-1:0]     fu_ready;

  logic [MAX_OPERANDS-1:0] prf_wen;
  prn_t                    prf_wprn  [MAX_OPERANDS];
  data_t                   prf_wdata [MAX_OPERANDS];
  logic                    rob_done_valid;
  inst_id_t                rob_done_inst_id;
  logic                    overflow_err;

  modport master (
    output fu_valid, fu_inst_id, fu_prn, fu_data, fu_data_valid,
    input  fu_ready, prf_wen, prf_wprn, prf_wdata, rob_done_valid, rob_done_inst_id, overflow_err
  );

  modport slave (
    input  fu_valid, fu_inst_id, fu_prn, fu_data, fu_data_valid,
    output fu_ready, prf_wen, prf_wprn, prf_wdata, rob_done_valid, rob_done_inst_id, overflow_err
  );
endinterface

// File: rtl/fu_wb_arbiter_fifo.sv
// Per-FU result FIFO (wb_fifo): FIFO_DEPTH beats, first-word-fall-through head, push+pop same edge
// allowed when full. A push that cannot be accepted is simply ignored; the parent flags it.
module wb_fifo
  import fu_wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  wb_beat_t push_beat,
  output wb_beat_t head,
  output cnt_t     count,
  output logic     full,
  output logic     empty
);

  wb_beat_t mem [FIFO_DEPTH];
  ptr_t     wr_ptr_reg;
  ptr_t     rd_ptr_reg;
  cnt_t     count_reg;
  logic     do_push;
  logic     do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == cnt_t'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_beat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU FIFOs, round-robin grant, registered PRF/ROB outputs, ready/overflow.
// Define WB_BYPASS_EN to let a lone beat skip its empty FIFO and reach the output one edge earlier.
module fu_wb_arbiter
  import fu_wb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fu_wb_arbiter_if.slave bus
);

  wb_beat_t            in_beat [FU_COUNT];
  wb_beat_t            head    [FU_COUNT];
  cnt_t                count   [FU_COUNT];
  occ_t                occ     [FU_COUNT];
  logic [FU_COUNT-1:0] empty;
  logic [FU_COUNT-1:0] full;
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;
  logic [FU_COUNT-1:0] dropped;
  logic [FU_COUNT-1:0] ready_next;

  rr_pick_t fifo_pick;
  rr_pick_t bypass_pick;
  logic     bypass_go;
  logic     grant_valid;
  fu_idx_t  grant_idx;
  wb_beat_t grant_beat;

  fu_idx_t  rr_reg;
  logic     rob_valid_reg;
  wb_beat_t out_beat_reg;
  logic     overflow_reg;

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      in_beat[f].inst_id    = bus.fu_inst_id[f];
      in_beat[f].data_valid = bus.fu_data_valid[f];
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        in_beat[f].prn[k]  = bus.fu_prn[f][k];
        in_beat[f].data[k] = bus.fu_data[f][k];
      end
    end
  end

  always_comb begin
    fifo_pick   = rr_pick(~empty, rr_reg);
    bypass_pick = rr_pick(bus.fu_valid, rr_reg);
    bypass_go   = 1'b0;
`ifdef WB_BYPASS_EN
    // Only when nothing is buffered anywhere, so per-FU order and fairness are unaffected.
    bypass_go   = (&empty) & bypass_pick.found;
`endif
    grant_valid = fifo_pick.found | bypass_go;
    grant_idx   = fifo_pick.found ? fifo_pick.idx : bypass_pick.idx;
    grant_beat  = fifo_pick.found ? head[fifo_pick.idx] : in_beat[bypass_pick.idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < FU_COUNT; gi++) begin : g_fu
      assign pop[gi]     = fifo_pick.found & (fifo_pick.idx == fu_idx_t'(gi));
      assign push[gi]    = bus.fu_valid[gi] & ~(bypass_go & (bypass_pick.idx == fu_idx_t'(gi)));
      assign dropped[gi] = push[gi] & full[gi] & ~pop[gi];
      assign occ[gi]     = {1'b0, count[gi]} + {{CNT_BITS{1'b0}}, bus.fu_valid[gi]};
      assign ready_next[gi] = rst & (occ[gi] <= OCC_LIMIT);

      wb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[gi]),
        .pop       (pop[gi]),
        .push_beat (in_beat[gi]),
        .head      (head[gi]),
        .count     (count[gi]),
        .full      (full[gi]),
        .empty     (empty[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_reg        <= '0;
      rob_valid_reg <= 1'b0;
      out_beat_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      rob_valid_reg <= grant_valid;
      out_beat_reg  <= grant_valid ? mask_beat(grant_beat) : '0;
      if (grant_valid) rr_reg <= rr_next(grant_idx);
      if (|dropped) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    bus.fu_ready         = ready_next;
    bus.prf_wen          = out_beat_reg.data_valid;
    bus.rob_done_valid   = rob_valid_reg;
    bus.rob_done_inst_id = out_beat_reg.inst_id;
    bus.overflow_err     = overflow_reg;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      bus.prf_wprn[k]  = out_beat_reg.prn[k];
      bus.prf_wdata[k] = out_beat_reg.data[k];
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: vector table + scoreboard of expected completions, plus multi-cycle
// sequences for contention, overflow and mid-operation reset. Honours WB_BYPASS_EN for latency.
module tb_fu_wb_arbiter;
  import fu_wb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fu_wb_arbiter_if bus ();
  fu_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    inst_id_t                id;
    logic [MAX_OPERANDS-1:0] wen;
    prn_t                    prn  [MAX_OPERANDS];
    data_t                   data [MAX_OPERANDS];
    int                      due;
  } exp_t;

  typedef struct {
    int                      fu;
    inst_id_t                id;
    logic [MAX_OPERANDS-1:0] dv;
    prn_t                    prn  [MAX_OPERANDS];
    data_t                   data [MAX_OPERANDS];
  } vin_t;

  typedef struct {
    vin_t in;
    exp_t exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   seen   = 0;
  bit   sb_on  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input int f, input inst_id_t id, input logic [2:0] dv,
                              input prn_t p0, input prn_t p1, input prn_t p2,
                              input data_t d0, input data_t d1, input data_t d2);
    vec_t v;
    v.in.fu = f;  v.in.id = id;  v.in.dv = dv;
    v.in.prn[0] = p0;  v.in.prn[1] = p1;  v.in.prn[2] = p2;
    v.in.data[0] = d0; v.in.data[1] = d1; v.in.data[2] = d2;
    v.exp.id  = id;
    v.exp.wen = dv;
    v.exp.due = -1;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      v.exp.prn[k]  = dv[k] ? v.in.prn[k]  : '0;
      v.exp.data[k] = dv[k] ? v.in.data[k] : '0;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    for (int f = 0; f < FU_COUNT; f++) begin
      bus.fu_valid[f]      = 1'b0;
      bus.fu_inst_id[f]    = '0;
      bus.fu_data_valid[f] = '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        bus.fu_prn[f][k]  = '0;
        bus.fu_data[f][k] = '0;
      end
    end
  endtask

  // Present a beat for the next edge; record the completion if the scoreboard should expect it.
  task automatic drive(input vec_t v, input int due, input bit expect_it);
    exp_t e;
    bus.fu_valid[v.in.fu]      = 1'b1;
    bus.fu_inst_id[v.in.fu]    = v.in.id;
    bus.fu_data_valid[v.in.fu] = v.in.dv;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      bus.fu_prn[v.in.fu][k]  = v.in.prn[k];
      bus.fu_data[v.in.fu][k] = v.in.data[k];
    end
    e = v.exp;
    e.due = due;
    if (expect_it) sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.rob_done_valid === 1'b1) begin
      seen++;
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", bus.rob_done_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          $display("done id=%0d wen=%b prn0=%0d data0=%0h at cycle %0d", bus.rob_done_inst_id,
                   bus.prf_wen, bus.prf_wprn[0], bus.prf_wdata[0], cyc);
          chk("inst_id", bus.rob_done_inst_id, e.id);
          chk("prf_wen", bus.prf_wen, e.wen);
          for (int k = 0; k < MAX_OPERANDS; k++) begin
            chk("prf_wprn", bus.prf_wprn[k], e.prn[k]);
            chk("prf_wdata", bus.prf_wdata[k], e.data[k]);
          end
          if (e.due >= 0) chk("latency_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (3) step();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("rst_rob_valid", bus.rob_done_valid, 1'b0);
    chk("rst_prf_wen", bus.prf_wen, '0);
    chk("rst_overflow", bus.overflow_err, 1'b0);
    chk("rst_fu_ready", bus.fu_ready, '0);
    repeat (2) step();
    rst = 1'b1;
    sb_q.delete();
    step();
    chk("post_rst_ready", bus.fu_ready, {FU_COUNT{1'b1}});
  endtask

  initial begin
    vecs[0] = mk(0, 6'd5,  3'b001, 6'd12, 6'd0,  6'd0,  64'hDEAD, 64'h0, 64'h0);
    vecs[1] = mk(1, 6'd17, 3'b111, 6'd1,  6'd2,  6'd3,  64'h1111, 64'h2222, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[2] = mk(2, 6'd33, 3'b010, 6'd40, 6'd41, 6'd42, 64'hA, 64'hBEEF_CAFE_0123_4567, 64'hC);
    vecs[3] = mk(3, 6'd63, 3'b000, 6'd7,  6'd8,  6'd9,  64'h77, 64'h88, 64'h99);
    vecs[4] = mk(3, 6'd9,  3'b101, 6'd20, 6'd21, 6'd22, 64'h5, 64'h6, 64'h7);
    vecs[5] = mk(0, 6'd0,  3'b110, 6'd63, 6'd30, 6'd31, 64'hDEAD_BEEF, 64'h30, 64'h31);

    clear_inputs();
    do_reset();

    // Isolated beats, one FU at a time: exact latency, masking, single pulse.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i], cyc + LAT, 1'b1);
      step();
      clear_inputs();
      drain(10);
    end

    // All four FUs on one edge: round-robin order 1..4 on consecutive cycles.
    do_reset();
    for (int f = 0; f < FU_COUNT; f++)
      drive(mk(f, inst_id_t'(f + 1), 3'b001, prn_t'(f + 10), 6'd0, 6'd0, 64'(f * 3 + 1), 64'h0, 64'h0),
            cyc + LAT + f, 1'b1);
    step();
    clear_inputs();
    drain(12);
    // Pointer must be back at FU0: FU0 wins over FU3 on a simultaneous arrival.
    drive(mk(0, 6'd41, 3'b001, 6'd1, 6'd0, 6'd0, 64'h41, 64'h0, 64'h0), cyc + LAT, 1'b1);
    drive(mk(3, 6'd40, 3'b001, 6'd2, 6'd0, 6'd0, 64'h40, 64'h0, 64'h0), cyc + LAT + 1, 1'b1);
    step();
    clear_inputs();
    drain(10);

    // FU2 streaming alone: one completion per cycle, never throttled.
    do_reset();
    for (int j = 0; j < 10; j++) begin
      drive(mk(2, inst_id_t'(10 + j), 3'b011, prn_t'(j), prn_t'(j + 1), 6'd0,
               64'(j * 7), 64'(j * 9), 64'h0), cyc + LAT, 1'b1);
      #1;
      chk("stream_ready_fu2", bus.fu_ready[2], 1'b1);
      step();
    end
    clear_inputs();
    drain(10);
    chk("stream_no_overflow", bus.overflow_err, 1'b0);

    // All FUs saturated for 6 edges: FU1 throttled, FIFOs overflow, overflow_err sticky.
    do_reset();
    sb_on = 1'b0;
    seen  = 0;
    for (int j = 0; j < 6; j++) begin
      for (int f = 0; f < FU_COUNT; f++)
        drive(mk(f, inst_id_t'(f == 1 ? 20 + j : 32 + f * 6 + j), 3'b001, prn_t'(j), 6'd0, 6'd0,
                 64'(j), 64'h0, 64'h0), -1, 1'b0);
      #1;
      if (j == 0) chk("burst_ready_fu1_start", bus.fu_ready[1], 1'b1);
      if (j >= 3) chk("burst_ready_fu1_low", bus.fu_ready[1], 1'b0);
      step();
    end
    clear_inputs();
    step();
    chk("overflow_set", bus.overflow_err, 1'b1);
    repeat (30) step();
    chk("overflow_sticky", bus.overflow_err, 1'b1);
    chk("burst_completions", 64'(seen), (LAT == 1) ? 64'd22 : 64'd21);
    chk("burst_ready_after", bus.fu_ready, {FU_COUNT{1'b1}});
    sb_on = 1'b1;

    // Reset with beats still buffered: outputs clear at once, nothing completes afterwards.
    do_reset();
    sb_on = 1'b0;
    for (int f = 0; f < FU_COUNT; f++)
      drive(mk(f, inst_id_t'(50 + f), 3'b111, 6'd5, 6'd6, 6'd7, 64'h50, 64'h51, 64'h52), -1, 1'b0);
    step();
    clear_inputs();
    step();
    chk("pre_reset_valid", bus.rob_done_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", bus.rob_done_valid, 1'b0);
    chk("async_rst_wen", bus.prf_wen, '0);
    chk("async_rst_id", bus.rob_done_inst_id, '0);
    step();
    rst   = 1'b1;
    seen  = 0;
    sb_on = 1'b1;
    repeat (8) step();
    chk("post_rst_completions", 64'(seen), 64'd0);
    drive(mk(1, 6'd7, 3'b100, 6'd1, 6'd2, 6'd3, 64'h1, 64'h2, 64'h3), cyc + LAT, 1'b1);
    step();
    clear_inputs();
    drain(10);

    // Idle arbiter, FU3 id 9: latency is 1 edge with bypass, 2 without.
    do_reset();
    drive(mk(3, 6'd9, 3'b001, 6'd33, 6'd0, 6'd0, 64'h9, 64'h0, 64'h0), cyc + LAT, 1'b1);
    step();
    clear_inputs();
    drain(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
